// File: rtl/isi_pkg.sv
// Shared types and constants for the inter-spike-interval capture block.
package isi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CLRS  = 2'd2
    } state_t;

    localparam int ISI_W_DEF = 8;
    localparam int DROP_W    = 8;

endpackage

// File: rtl/isi_capture_if.sv
// Captured-interval output stream: show-ahead head entry with valid/ready.
interface isi_capture_if #(
    parameter int BIT_ISI = 8
) ();
    logic [BIT_ISI-1:0] out_isi;
    logic               out_of;
    logic               out_valid;
    logic               out_ready;

    modport master (output out_isi, out_of, out_valid, input out_ready);
    modport slave  (input out_isi, out_of, out_valid, output out_ready);
endinterface

// File: rtl/isi_fifo.sv
// Show-ahead capture buffer; a push into a full buffer succeeds only alongside a pop.
module isi_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

endmodule

// File: rtl/isi_capture.sv
// Captures the interval counter value on each spike rising edge, then clears
// the counter for the next interval; results queue in a small buffer.
module isi_capture
    import isi_pkg::*;
#(
    parameter int BIT_ISI    = ISI_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic               spike,
    input  logic               tick,
    input  logic [BIT_ISI-1:0] isi_q,
    input  logic               isi_of,
    output logic               isi_ce,
    output logic               isi_clr,
    output logic [DROP_W-1:0]  drop_cnt,
    isi_capture_if.master      out
);
    state_t         state, state_nxt;
    logic           spike_d;
    logic           spk_edge;
    logic           capture;
    logic           full, empty;
    logic [BIT_ISI:0] head;

    assign spk_edge = spike & ~spike_d;
    assign capture  = en & (state == ARMED) & spk_edge;
    // Counting is frozen in the edge cycle so the captured value is stable.
    assign isi_ce   = (state == ARMED) & tick & ~spk_edge;

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (spk_edge) state_nxt = CLRS;
                ARMED:   if (spk_edge) state_nxt = CLRS;
                CLRS:    state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            spike_d  <= 1'b0;
            isi_clr  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state   <= state_nxt;
            spike_d <= spike;
            isi_clr <= (state_nxt == CLRS);
            if (capture && full && !out.out_ready && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    isi_fifo #(
        .WIDTH (BIT_ISI + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (capture),
        .din   ({isi_of, isi_q}),
        .pop   (out.out_ready),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign out.out_valid = ~empty;
    assign out.out_of    = head[BIT_ISI];
    assign out.out_isi   = head[BIT_ISI-1:0];

endmodule

// File: tb/tb_isi_capture.sv
// Randomized and directed checks of isi_capture against an event-level model
// plus a model of the downstream interval counter.
module tb_isi_capture;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         clr, en, spike, tick, isi_of;
    logic [W-1:0] isi_q;
    logic         isi_ce, isi_clr;
    logic [7:0]   drop_cnt;

    isi_capture_if #(.BIT_ISI(W)) bus ();

    isi_capture #(.BIT_ISI(W), .FIFO_DEPTH(D)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .spike    (spike),
        .tick     (tick),
        .isi_q    (isi_q),
        .isi_of   (isi_of),
        .isi_ce   (isi_ce),
        .isi_clr  (isi_clr),
        .drop_cnt (drop_cnt),
        .out      (bus)
    );

    always #5 clk = ~clk;

    // downstream counter
    int   cnt = 0;
    logic cof = 1'b0;
    // event-level model
    logic [W:0] mq[$];
    int   m_drop = 0;
    bit   m_armed = 0, m_pend = 0, m_sp = 0, m_ok = 0;
    int   n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic cyc(input logic s, input logic tk, input logic e, input logic r, input logic c);
        bit   ed, pop, cap, acc, full_b;
        logic sce, sclr;
        spike = s; tick = tk; en = e; bus.out_ready = r; clr = c;
        isi_q = cnt[W-1:0]; isi_of = cof;
        @(negedge clk);
        ed = s && !m_sp;
        if (m_ok) begin
            chk("isi_ce",    32'(isi_ce),        32'(m_armed && !m_pend && tk && !ed));
            chk("isi_clr",   32'(isi_clr),       32'(m_pend));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("out_isi",   32'(bus.out_isi),   mq.size() != 0 ? 32'(mq[0][W-1:0]) : 32'd0);
            chk("out_of",    32'(bus.out_of),    mq.size() != 0 ? 32'(mq[0][W])     : 32'd0);
            chk("drop_cnt",  32'(drop_cnt),      32'(m_drop));
        end
        sce = isi_ce; sclr = isi_clr;
        @(posedge clk);
        if (sclr === 1'b1) begin
            cnt = 0; cof = 1'b0;
        end else if (sce === 1'b1) begin
            if (cnt == 255) begin cnt = 0; cof = 1'b1; end
            else cnt++;
        end
        if (c) begin
            mq.delete(); m_drop = 0; m_armed = 0; m_pend = 0; m_sp = 0; m_ok = 1;
        end else begin
            full_b = mq.size() >= D;
            pop    = r && mq.size() != 0;
            acc    = e && ed && !m_pend;
            cap    = acc && m_armed;
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (!full_b || pop) mq.push_back({isi_of, isi_q});
                else if (m_drop < 255) m_drop++;
            end
            m_pend  = acc;
            m_armed = e && (m_armed || acc);
            m_sp    = s;
        end
        #1;
    endtask

    initial begin
        repeat (3) cyc(0, 0, 0, 0, 1);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_drop",  32'(drop_cnt),      32'd0);
        chk("rst_clr",   32'(isi_clr),       32'd0);

        // first edge arms, second edge 20 cycles later captures 18
        repeat (5) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("arm_noentry", 32'(bus.out_valid), 32'd0);
        chk("arm_clr",     32'(isi_clr),       32'd1);
        repeat (19) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("basic_isi",   32'(bus.out_isi),   32'd18);
        chk("basic_valid", 32'(bus.out_valid), 32'd1);
        chk("basic_clr",   32'(isi_clr),       32'd1);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 0);

        // long interval: counter wraps past 255 and flags overflow
        repeat (300) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("ovf_of",  32'(bus.out_of),  32'd1);
        chk("ovf_isi", 32'(bus.out_isi), 32'd45);
        repeat (2) cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);

        // 6 intervals into a 4-deep buffer
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1'($urandom % 2), 1, 0, 0);
            repeat (2 + $urandom % 5) cyc(0, 1'($urandom % 2), 1, 0, 0);
        end
        chk("full_drop",  32'(drop_cnt),      32'd2);
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        repeat (4) cyc(0, 1, 1, 1, 0);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // full buffer, push coincides with pop
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 1, 0, 0);
            repeat (3) cyc(0, 1, 1, 0, 0);
        end
        cyc(1, 1, 1, 1, 0);
        chk("pushpop_drop", 32'(drop_cnt), 32'd2);
        repeat (3) cyc(0, 1, 1, 0, 0);
        repeat (5) cyc(0, 1, 1, 1, 0);

        // reset during the counter-clear cycle
        cyc(1, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 1);
        chk("clrs_rst_clr",   32'(isi_clr),       32'd0);
        chk("clrs_rst_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) cyc(0, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("rearm_noentry", 32'(bus.out_valid), 32'd0);
        repeat (4) cyc(0, 1, 1, 0, 0);

        // enable dropped while armed with two entries queued
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 1, 0, 0);
            repeat (3) cyc(0, 1, 1, 0, 0);
        end
        cyc(0, 1, 0, 0, 0);
        chk("en_off_ce", 32'(isi_ce), 32'd0);
        repeat (3) cyc(0, 1, 0, 1, 0);
        chk("en_off_drained", 32'(bus.out_valid), 32'd0);

        // drop counter saturation
        cyc(0, 0, 0, 0, 1);
        repeat (270) begin
            cyc(1, 1, 1, 0, 0);
            cyc(0, 1, 1, 0, 0);
        end
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        repeat (3000)
            cyc(1'($urandom % 3 == 0), 1'($urandom % 2), 1'($urandom % 16 != 0),
                1'($urandom % 4 == 0), 1'($urandom % 200 == 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
